// File: rtl/alu_regfile_seq_if.sv
// Command/result bus of the ALU register-file datapath.
// Master is the sequencer side, slave is the datapath side.
interface alu_regfile_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
);
    localparam int RI = $clog2(NREG);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             src_sel;
    logic [RI-1:0]    rs;
    logic [1:0]       shift_mode;
    logic             wr_en;
    logic [RI-1:0]    rd;
    logic             out_en;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_neg;

    modport master (
        output in_valid, op, a, b, src_sel, rs,
        output shift_mode, wr_en, rd, out_en,
        input  in_ready, z, z_valid,
        input  flag_zero, flag_carry, flag_neg
    );

    modport slave (
        input  in_valid, op, a, b, src_sel, rs,
        input  shift_mode, wr_en, rd, out_en,
        output in_ready, z, z_valid,
        output flag_zero, flag_carry, flag_neg
    );
endinterface

// File: rtl/alu_regfile_seq.sv
// Parametrised ALU with register file, status flags,
// valid/ready command input and multi-cycle shift-add multiply.
module alu_regfile_seq #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_regfile_seq_if.slave   bus
);
    localparam int RI = $clog2(NREG);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   regs [NREG];

    logic [WIDTH-1:0]   m_a;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [1:0]         l_sm;
    logic               l_wr;
    logic               l_oe;
    logic [RI-1:0]      l_rd;

    logic [WIDTH-1:0]   z_q;
    logic               zv_q;
    logic               fz_q;
    logic               fc_q;
    logic               fn_q;

    logic               accept;
    logic               sc_go;
    logic [WIDTH-1:0]   s;
    logic [WIDTH:0]     alu_w;
    logic [WIDTH-1:0]   sc_res;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_c;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] acc_nxt;

    logic               rf_we;
    logic [RI-1:0]      rf_wa;
    logic [WIDTH-1:0]   rf_wd;
    logic               z_we;
    logic [WIDTH-1:0]   z_wd;
    logic               z_c;

    function automatic logic [WIDTH-1:0] shf(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            2'b00: r = v;
            2'b01: r = {1'b0, v[WIDTH-1:1]};
            2'b10: r = {v[WIDTH-3:0], 2'b00};
            2'b11: r = {v[WIDTH-2:0], 1'b0};
            default: r = v;
        endcase
        return r;
    endfunction

    assign bus.in_ready   = (state == IDLE) && !rst;
    assign accept         = bus.in_valid && bus.in_ready;
    assign sc_go          = accept && (bus.op != 3'b000);
    assign s              = bus.src_sel ? regs[bus.rs] : bus.b;

    assign bus.z          = z_q;
    assign bus.z_valid    = zv_q;
    assign bus.flag_zero  = fz_q;
    assign bus.flag_carry = fc_q;
    assign bus.flag_neg   = fn_q;

    // Single-cycle op: bit WIDTH carries carry-out or borrow
    always_comb begin
        alu_w = '0;
        unique case (bus.op)
            3'b000: alu_w = '0;
            3'b001: alu_w = {1'b0, s};
            3'b010: alu_w = {1'b0, bus.a} + {1'b0, s};
            3'b011: alu_w = {1'b0, bus.a} - {1'b0, s};
            3'b100: alu_w = {1'b0, s} - {1'b0, bus.a};
            3'b101: alu_w = {1'b0, bus.a & s};
            3'b110: alu_w = {1'b0, bus.a | s};
            3'b111: alu_w = {1'b0, bus.a ^ s};
            default: alu_w = '0;
        endcase
    end

    assign sc_res  = shf(alu_w[WIDTH-1:0], bus.shift_mode);
    assign mul_res = shf(acc[WIDTH-1:0], l_sm);
    assign mul_c   = |acc[2*WIDTH-1:WIDTH];

    // One shift-add step: add multiplicand to the high half, shift right
    always_comb begin
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0])
            msum = msum + {1'b0, m_a};
        acc_nxt = {msum, acc[WIDTH-1:1]};
    end

    // Write-back select: MUL completion or a live single-cycle command
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        z_we  = 1'b0;
        z_wd  = '0;
        z_c   = 1'b0;
        if (state == DONE) begin
            rf_we = l_wr;
            rf_wa = l_rd;
            rf_wd = mul_res;
            z_we  = l_oe;
            z_wd  = mul_res;
            z_c   = mul_c;
        end else if (sc_go) begin
            rf_we = bus.wr_en;
            rf_wa = bus.rd;
            rf_wd = sc_res;
            z_we  = bus.out_en;
            z_wd  = sc_res;
            z_c   = alu_w[WIDTH];
        end
    end

    // Sequencer FSM and multiplier state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m_a   <= '0;
            acc   <= '0;
            cnt   <= '0;
            l_sm  <= '0;
            l_wr  <= 1'b0;
            l_oe  <= 1'b0;
            l_rd  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && bus.op == 3'b000) begin
                        state <= MUL;
                        m_a   <= bus.a;
                        acc   <= {{WIDTH{1'b0}}, s};
                        cnt   <= CW'(WIDTH - 1);
                        l_sm  <= bus.shift_mode;
                        l_wr  <= bus.wr_en;
                        l_oe  <= bus.out_en;
                        l_rd  <= bus.rd;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (rf_we) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    // Result register, flags and one-cycle valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q  <= '0;
            zv_q <= 1'b0;
            fz_q <= 1'b0;
            fc_q <= 1'b0;
            fn_q <= 1'b0;
        end else begin
            zv_q <= z_we;
            if (z_we) begin
                z_q  <= z_wd;
                fz_q <= (z_wd == '0);
                fc_q <= z_c;
                fn_q <= z_wd[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed and randomized checks of alu_regfile_seq
// against a behavioural arithmetic model.
module tb_alu_regfile_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    longint   mregs [4];
    longint   mz;
    logic [2:0] mfl;

    alu_regfile_seq_if #(.WIDTH(16), .NREG(4)) bus ();

    alu_regfile_seq #(.WIDTH(16), .NREG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mz  = 0;
        mfl = 3'b000;
    endtask

    function automatic void model_eval(
        input int op, input longint a, input longint s, input int sm,
        output longint r, output bit c);
        longint t;
        c = 1'b0;
        t = 0;
        case (op)
            0: begin t = a * s; c = (t >> 16) != 0; end
            1: t = s;
            2: begin t = a + s; c = t > 65535; end
            3: begin t = a - s; c = a < s; end
            4: begin t = s - a; c = s < a; end
            5: t = a & s;
            6: t = a | s;
            default: t = a ^ s;
        endcase
        t = t & 64'hFFFF;
        case (sm)
            1: t = t >> 1;
            2: t = (t << 2) & 64'hFFFF;
            3: t = (t << 1) & 64'hFFFF;
            default: ;
        endcase
        r = t;
    endfunction

    task automatic checks(input string tag);
        chk({tag, "_z"}, 32'(bus.z), 32'(mz));
        chk({tag, "_flags"},
            32'({bus.flag_zero, bus.flag_carry, bus.flag_neg}),
            32'(mfl));
    endtask

    // Called at a falling edge; returns at the falling edge
    // where the command's result is visible.
    task automatic issue(input string tag, input int op,
                         input int a, input int b, input bit ss,
                         input int rs, input int sm, input bit wr,
                         input int rd, input bit oe);
        longint s;
        longint r;
        bit     c;
        int     n;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.op         = 3'(op);
        bus.a          = 16'(a);
        bus.b          = 16'(b);
        bus.src_sel    = ss;
        bus.rs         = 2'(rs);
        bus.shift_mode = 2'(sm);
        bus.wr_en      = wr;
        bus.rd         = 2'(rd);
        bus.out_en     = oe;
        bus.in_valid   = 1'b1;
        s = ss ? mregs[rs] : longint'(b);
        model_eval(op, longint'(a), s, sm, r, c);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 3'(7 - op);
        bus.a        = 16'($urandom);
        if (op == 0) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk({tag, "_busy"}, 32'(n), 32'd17);
        end
        if (wr) mregs[rd] = r;
        if (oe) begin
            mz  = r;
            mfl = {r == 0, c, r[15]};
        end
        chk({tag, "_zv"}, 32'(bus.z_valid), 32'(oe));
        checks(tag);
    endtask

    initial begin
        int pulses;
        int op;
        model_reset();
        bus.in_valid   = 1'b0;
        bus.op         = '0;
        bus.a          = '0;
        bus.b          = '0;
        bus.src_sel    = 1'b0;
        bus.rs         = '0;
        bus.shift_mode = '0;
        bus.wr_en      = 1'b0;
        bus.rd         = '0;
        bus.out_en     = 1'b0;

        // reset for 3 cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        end
        chk("rst_zv", 32'(bus.z_valid), 32'd0);
        checks("rst");
        rst = 1'b0;
        #1;
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            issue("rd0", 1, 0, 16'hFFFF, 1'b1, k, 0, 1'b0, 0, 1'b1);
            chk("rd0_const", 32'(bus.z), 32'h0);
        end

        // ADD wrap
        issue("add", 2, 16'hFFFF, 16'h0001, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        chk("add_zf", 32'({bus.z, bus.flag_zero, bus.flag_carry,
                          bus.flag_neg}), 32'h0000_0006);
        @(negedge clk);
        chk("add_zv_off", 32'(bus.z_valid), 32'd0);

        // register write then SUB / RSUB from it
        issue("pass", 1, 0, 16'h1234, 1'b0, 0, 0, 1'b1, 2, 1'b0);
        issue("sub", 3, 16'h1235, 16'hAAAA, 1'b1, 2, 0, 1'b0, 0, 1'b1);
        chk("sub_c", 32'({bus.z, bus.flag_carry}), 32'h0000_0002);
        issue("rsub", 4, 16'h1235, 16'hAAAA, 1'b1, 2, 0, 1'b0, 0, 1'b1);
        chk("rsub_f", 32'({bus.z, bus.flag_carry, bus.flag_neg}),
            32'h0003_FFFF);

        // shift modes
        issue("sr1", 6, 16'h8001, 0, 1'b0, 0, 1, 1'b0, 0, 1'b1);
        chk("sr1_c", 32'(bus.z), 32'h4000);
        issue("sl2", 6, 16'h8001, 0, 1'b0, 0, 2, 1'b0, 0, 1'b1);
        chk("sl2_c", 32'(bus.z), 32'h0004);
        issue("sl1", 6, 16'h8001, 0, 1'b0, 0, 3, 1'b0, 0, 1'b1);
        chk("sl1_c", 32'({bus.z, bus.flag_neg}), 32'h0000_0004);

        // multiply
        issue("mul", 0, 3, 5, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        chk("mul_c", 32'({bus.z, bus.flag_carry}), 32'h0000_001E);
        @(negedge clk);
        chk("mul_zv_off", 32'(bus.z_valid), 32'd0);
        issue("mulov", 0, 16'h0100, 16'h0100, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        chk("mulov_c", 32'({bus.z, bus.flag_zero, bus.flag_carry}),
            32'h0000_0003);

        // randomized commands, sometimes with idle gaps
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            if (op == 0 && $urandom_range(0, 2) != 0)
                op = $urandom_range(1, 7);
            issue("rnd", op, $urandom_range(0, 65535),
                  $urandom_range(0, 65535), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), $urandom_range(0, 3), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                bus.out_en = 1'($urandom);
                bus.wr_en  = 1'($urandom);
                @(negedge clk);
                chk("gap_zv", 32'(bus.z_valid), 32'd0);
                checks("gap");
            end
        end

        // reset in the middle of a multiply
        issue("pre", 1, 0, 16'h5A5A, 1'b0, 0, 0, 1'b1, 1, 1'b1);
        bus.op       = 3'b000;
        bus.a        = 16'h0007;
        bus.b        = 16'h0009;
        bus.src_sel  = 1'b0;
        bus.wr_en    = 1'b1;
        bus.rd       = 2'd1;
        bus.out_en   = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("abort_rdy", 32'(bus.in_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("abort_rel_rdy", 32'(bus.in_ready), 32'd1);
        checks("abort");
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.z_valid !== 1'b0) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_z", 32'(bus.z), 32'h0);
        issue("abort_r1", 1, 0, 16'hABCD, 1'b1, 1, 0, 1'b0, 0, 1'b1);
        chk("abort_r1_c", 32'(bus.z), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
Parametrised successor to the team's 8-bit two-register ALU datapath. It generalises data width and register count, selects write-back and operand registers by index, and adds status flags and a valid/ready input handshake. It also adds a multi-cycle shift-add multiply. It sits between the sequencer/control FSM and downstream consumers of the z result.

Parameters:
WIDTH, 16, datapath and register width in bits (>=4).
NREG, 4, number of internal general registers (power of 2, >=2); index width RI = clog2(NREG), derived locally.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  command valid
in_ready  output  1  block can accept a command (high only in IDLE and rst low)
op  input  3  000 MUL, 001 PASS, 010 ADD, 011 SUB (a-s), 100 RSUB (s-a), 101 AND, 110 OR, 111 XOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
src_sel  input  1  second operand s: 0 = b, 1 = reg[rs]
rs  input  RI  source register index
shift_mode  input  2  post-op shift: 00 none, 01 logical right 1, 10 left 2, 11 left 1 (zero fill)
wr_en  input  1  write shifted result into reg[rd]
rd  input  RI  destination register index
out_en  input  1  load shifted result into z
z  output  WIDTH  registered result
z_valid  output  1  one-cycle pulse when z updates
flag_zero  output  1  result == 0
flag_carry  output  1  carry/borrow/overflow (see below)
flag_neg  output  1  result MSB

Behaviour:
- Reset (async, rst high): z=0, z_valid=0, all flags=0, all reg[]=0, FSM=IDLE, in_ready=0 while rst high, 1 on the first cycle after release.
- Accept = in_valid && in_ready, sampled on the rising edge. All command fields are captured at accept. Inputs are don't-care otherwise.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> IDLE on non-MUL accept.
  - IDLE -> MUL on MUL accept.
  - MUL -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE unconditionally.
- Single-cycle ops (op != 000): compute s, op result, then shift, combinationally from the live inputs. At the accept edge:
  - if out_en: z <= result, flags updated, z_valid=1 for the following cycle.
  - if wr_en: reg[rd] <= result.
  - Latency 1 cycle. Back-to-back accepts every cycle.
- Arithmetic is modulo 2^WIDTH before the shift.
- flag_carry:
  - ADD: carry-out.
  - SUB/RSUB: borrow (1 when the minuend is less than the subtrahend, unsigned).
  - PASS/AND/OR/XOR: 0.
  - MUL: 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero.
- flag_zero and flag_neg are taken from the post-shift result. Flags update only when z updates (out_en).
- MUL: shift-add over WIDTH cycles in MUL state.
  - Operands a and s are latched at accept, and a 2*WIDTH accumulator is used.
  - in_ready=0 in MUL and DONE.
  - At the DONE edge, the low WIDTH bits are shifted per the latched shift_mode and written to z/reg[rd] per the latched out_en/wr_en.
  - z_valid pulses the cycle after DONE. Total latency from accept to z valid = WIDTH+2 edges.
- Register read is combinational from the current register contents. If a command has rs == rd, it reads the old value and writes the new one.
- A command issued the cycle after a write to reg[k] with rs=k sees the new value; no bypass is needed.
- z holds its value when out_en=0. z_valid is 0 on every cycle not following an update.
- Reset mid-MUL aborts the operation: no write-back, no z_valid, FSM returns to IDLE.
- With out_en=0 and wr_en=0 the command is accepted and consumed with no visible effect; for MUL, in_ready is still low for the full duration.

Test Plan:
All scenarios use WIDTH=16, NREG=4.
1. Assert rst for 3 cycles, release -> z=0x0000, z_valid=0, flags=000, in_ready=0 during rst and 1 on the cycle after release; src_sel=1 reads 0x0000 from every reg.
2. ADD a=0xFFFF b=0x0001 out_en=1 -> next cycle z=0x0000, zero=1, carry=1, neg=0, z_valid=1 for exactly one cycle.
3. PASS b=0x1234 wr_en=1 rd=2 out_en=0, then SUB a=0x1235 src_sel=1 rs=2 out_en=1 -> z=0x0001, carry=0. Then RSUB with the same operands -> z=0xFFFF, carry=1, neg=1.
4. OR a=0x8001 b=0x0000:
   - shift_mode=01 -> z=0x4000.
   - shift_mode=10 -> z=0x0004.
   - shift_mode=11 -> z=0x0002, neg=0.
5. MUL a=0x0003 b=0x0005 out_en=1 -> in_ready low for 17 cycles after accept, z=0x000F with z_valid 18 edges after accept, carry=0. Then MUL a=0x0100 b=0x0100 -> z=0x0000, zero=1, carry=1.
6. MUL a=0x0007 b=0x0009 wr_en=1 rd=1 out_en=1, assert rst 5 cycles after accept -> z stays 0x0000, z_valid never pulses, reg[1]=0x0000, in_ready=1 the cycle after rst release.
